// File: rtl/rock_pkg.sv
// Shared types and default constants for the cradle rocking sequencer.
package rock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_EVAL,
    HOLD,
    ADVANCE,
    ALARM,
    SOFT_STOP
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    DOWN,
    EQUAL,
    UP
  } verdict_t;

  localparam int DEF_N_PATTERNS     = 5;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_MAX_SWEEPS     = 3;
  localparam int DEF_SOFT_CYCLES    = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rock_timer.sv
// Loadable down-counter shared by the settle, timeout and soft-stop intervals.
module rock_timer #(
  parameter int WIDTH = 7
) (
  input  logic             slow,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] value;

  // Counts down to zero and rests there until the next load.
  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/rock_sequencer.sv
// Rocking-pattern scheduler steered by stress verdicts from the heart-rate detector.
// Optional soft stop (motor keeps running at pattern 0 for a while) via ROCK_SEQ_SOFT_STOP_EN.
module rock_sequencer
  import rock_pkg::*;
#(
  parameter  int N_PATTERNS     = DEF_N_PATTERNS,
  parameter  int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int MAX_SWEEPS     = DEF_MAX_SWEEPS,
  parameter  int SOFT_CYCLES    = DEF_SOFT_CYCLES,
  localparam int PW             = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1
) (
  input  logic          slow,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          eval_pulse,
  input  logic          stress_down,
  input  logic          stress_up,
  output logic [PW-1:0] pattern,
  output logic          motor_en,
  output logic          det_clear,
  output logic          alarm,
  output logic          busy
);

  localparam int TW = $clog2(max3(SETTLE_CYCLES, TIMEOUT_CYCLES, SOFT_CYCLES) + 1);
  localparam int SW = $clog2(MAX_SWEEPS + 1);
  localparam logic [PW-1:0] LAST_PATTERN = PW'(N_PATTERNS - 1);
  localparam logic [SW-1:0] LAST_SWEEP   = SW'(MAX_SWEEPS - 1);

  state_t        state, state_n;
  logic [PW-1:0] pattern_n;
  logic [SW-1:0] sweep, sweep_n;
  logic          det_clear_n;
  logic          eval_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;
  verdict_t      verdict;

  rock_timer #(.WIDTH(TW)) u_timer (
    .slow       (slow),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  // A verdict exists only on the rising edge of eval_pulse; UP wins over DOWN.
  always_comb begin
    verdict = NONE;
    if (eval_pulse && !eval_q) begin
      if (stress_up)        verdict = UP;
      else if (stress_down) verdict = DOWN;
      else                  verdict = EQUAL;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pattern   <= '0;
      sweep     <= '0;
      det_clear <= 1'b0;
      eval_q    <= 1'b0;
    end else begin
      state     <= state_n;
      pattern   <= pattern_n;
      sweep     <= sweep_n;
      det_clear <= det_clear_n;
      eval_q    <= eval_pulse;
    end
  end

  always_comb begin
    state_n     = state;
    pattern_n   = pattern;
    sweep_n     = sweep;
    det_clear_n = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SETTLE;
          pattern_n   = '0;
          sweep_n     = '0;
          det_clear_n = 1'b1;
          tmr_load    = 1'b1;
          tmr_value   = TW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_n   = WAIT_EVAL;
          tmr_load  = 1'b1;
          tmr_value = TW'(TIMEOUT_CYCLES - 1);
        end
      end
      WAIT_EVAL: begin
        if (verdict == DOWN) begin
          state_n = HOLD;
          sweep_n = '0;
        end else if (verdict == UP || tmr_zero) begin
          state_n = ADVANCE;
        end
      end
      HOLD: begin
        if (verdict == UP) state_n = ADVANCE;
      end
      // A wrap back to pattern 0 completes one full sweep without relief.
      ADVANCE: begin
        if (pattern == LAST_PATTERN) begin
          pattern_n = '0;
          sweep_n   = sweep + 1'b1;
        end else begin
          pattern_n = pattern + 1'b1;
        end
        if (pattern == LAST_PATTERN && sweep == LAST_SWEEP) begin
          state_n = ALARM;
        end else begin
          state_n     = SETTLE;
          det_clear_n = 1'b1;
          tmr_load    = 1'b1;
          tmr_value   = TW'(SETTLE_CYCLES - 1);
        end
      end
      ALARM: begin
        state_n = ALARM;
      end
`ifdef ROCK_SEQ_SOFT_STOP_EN
      SOFT_STOP: begin
        if (tmr_zero) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    // stop outranks every verdict and timer event decided above.
    if (stop && state != IDLE) begin
      pattern_n   = '0;
      det_clear_n = 1'b0;
      tmr_load    = 1'b0;
      tmr_value   = '0;
`ifdef ROCK_SEQ_SOFT_STOP_EN
      if (state inside {SETTLE, WAIT_EVAL, HOLD}) begin
        state_n   = SOFT_STOP;
        tmr_load  = 1'b1;
        tmr_value = TW'(SOFT_CYCLES - 1);
      end else begin
        state_n = IDLE;
      end
`else
      state_n = IDLE;
`endif
    end
  end

  assign busy     = (state != IDLE);
  assign alarm    = (state == ALARM);
  assign motor_en = busy && !alarm;

endmodule

// File: tb/tb_rock_sequencer.sv
// Self-checking bench for rock_sequencer: cycle-level behavioural model plus directed literal checks.
module tb_rock_sequencer;

  localparam int N_PAT   = 5;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 64;
  localparam int SWEEPS  = 3;
  localparam int SOFT    = 16;

  localparam int P_IDLE   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_WAIT   = 2;
  localparam int P_HOLD   = 3;
  localparam int P_ADV    = 4;
  localparam int P_ALARM  = 5;
  localparam int P_SOFT   = 6;

  logic       slow = 1'b0;
  logic       reset;
  logic       start, stop, eval_pulse, stress_down, stress_up;
  logic [2:0] pattern;
  logic       motor_en, det_clear, alarm, busy;

  int checks = 0;
  int passes = 0;

  int m_phase = P_IDLE;
  int m_pattern = 0;
  int m_sweeps = 0;
  int m_left = 0;
  bit m_det = 1'b0;
  bit m_eval_q = 1'b0;
  bit m_rise;
  bit m_up;
  bit m_down;

  rock_sequencer #(
    .N_PATTERNS     (N_PAT),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MAX_SWEEPS     (SWEEPS),
    .SOFT_CYCLES    (SOFT)
  ) dut (
    .slow        (slow),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .eval_pulse  (eval_pulse),
    .stress_down (stress_down),
    .stress_up   (stress_up),
    .pattern     (pattern),
    .motor_en    (motor_en),
    .det_clear   (det_clear),
    .alarm       (alarm),
    .busy        (busy)
  );

  always #5 slow = ~slow;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic apply_stimulus(input logic s, input logic p, input logic e, input logic d, input logic u);
    start = s; stop = p; eval_pulse = e; stress_down = d; stress_up = u;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge slow);
  endtask

  // Behavioural model: phases with remaining-cycle budgets, advanced once per clock.
  always @(posedge slow or posedge reset) begin
    if (reset) begin
      m_phase = P_IDLE; m_pattern = 0; m_sweeps = 0; m_left = 0; m_det = 0; m_eval_q = 0;
    end else begin
      m_rise = eval_pulse && !m_eval_q;
      m_eval_q = eval_pulse;
      m_up = m_rise && stress_up;
      m_down = m_rise && stress_down && !stress_up;
      m_det = 0;
      if (stop && m_phase != P_IDLE) begin
        m_pattern = 0;
`ifdef ROCK_SEQ_SOFT_STOP_EN
        if (m_phase == P_SETTLE || m_phase == P_WAIT || m_phase == P_HOLD) begin
          m_phase = P_SOFT; m_left = SOFT;
        end else m_phase = P_IDLE;
`else
        m_phase = P_IDLE;
`endif
      end else begin
        case (m_phase)
          P_IDLE: if (start) begin
            m_phase = P_SETTLE; m_left = SETTLE; m_pattern = 0; m_sweeps = 0; m_det = 1;
          end
          P_SETTLE: begin
            m_left--;
            if (m_left == 0) begin m_phase = P_WAIT; m_left = TIMEOUT; end
          end
          P_WAIT: begin
            m_left--;
            if (m_down) begin m_phase = P_HOLD; m_sweeps = 0; end
            else if (m_up || m_left == 0) m_phase = P_ADV;
          end
          P_HOLD: if (m_up) m_phase = P_ADV;
          P_ADV: begin
            m_pattern = (m_pattern + 1) % N_PAT;
            if (m_pattern == 0) m_sweeps++;
            if (m_sweeps == SWEEPS) m_phase = P_ALARM;
            else begin m_phase = P_SETTLE; m_left = SETTLE; m_det = 1; end
          end
          P_SOFT: begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Every cycle out of reset the DUT must match the model.
  always @(negedge slow) begin
    if (!reset) begin
      check_output("cycle_model",
        32'({pattern, motor_en, det_clear, alarm, busy}),
        32'({3'(m_pattern),
             1'(m_phase != P_IDLE && m_phase != P_ALARM),
             m_det,
             1'(m_phase == P_ALARM),
             1'(m_phase != P_IDLE)}));
    end
  end

  initial begin
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0);
    tick(2);
    check_output("reset_pattern", 32'(pattern), 32'd0);
    check_output("reset_motor", 32'(motor_en), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_alarm", 32'(alarm), 32'd0);
    reset = 1'b0;
    tick(2);

    // start -> settle, one det_clear pulse, motor on after one cycle
    apply_stimulus(1, 0, 0, 0, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("start_motor", 32'(motor_en), 32'd1);
    check_output("start_detclr", 32'(det_clear), 32'd1);
    check_output("start_pattern", 32'(pattern), 32'd0);
    tick(1);
    check_output("detclr_single", 32'(det_clear), 32'd0);
    tick(7);

    // wide stress_up pulse in WAIT_EVAL -> exactly one advance
    apply_stimulus(0, 0, 1, 0, 1);
    tick(1);
    check_output("up_decision_pattern", 32'(pattern), 32'd0);
    tick(1);
    check_output("up_new_pattern", 32'(pattern), 32'd1);
    check_output("up_detclr", 32'(det_clear), 32'd1);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("up_single_advance", 32'(pattern), 32'd1);
    check_output("up_detclr_end", 32'(det_clear), 32'd0);

    // stress_down -> HOLD, no timeout for 200 cycles
    tick(7);
    apply_stimulus(0, 0, 1, 1, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    tick(200);
    check_output("hold_pattern", 32'(pattern), 32'd1);
    check_output("hold_motor", 32'(motor_en), 32'd1);

    // stop together with a stress_up edge in HOLD
    apply_stimulus(0, 1, 1, 0, 1);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("stop_pattern", 32'(pattern), 32'd0);
`ifdef ROCK_SEQ_SOFT_STOP_EN
    check_output("stop_motor", 32'(motor_en), 32'd1);
    check_output("stop_busy", 32'(busy), 32'd1);
`else
    check_output("stop_motor", 32'(motor_en), 32'd0);
    check_output("stop_busy", 32'(busy), 32'd0);
`endif
    tick(2);
    check_output("stop_no_advance", 32'(pattern), 32'd0);
    tick(13);
`ifdef ROCK_SEQ_SOFT_STOP_EN
    check_output("soft_last_cycle", 32'(motor_en), 32'd1);
`else
    check_output("soft_last_cycle", 32'(motor_en), 32'd0);
`endif
    tick(1);
    check_output("stop_done_motor", 32'(motor_en), 32'd0);

    // no verdicts: timeouts sweep patterns until alarm
    apply_stimulus(1, 0, 0, 0, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    tick(72);
    check_output("timeout_before", 32'(pattern), 32'd0);
    tick(1);
    check_output("timeout_advance", 32'(pattern), 32'd1);
    tick(1021);
    check_output("pre_alarm_pattern", 32'(pattern), 32'd4);
    check_output("pre_alarm_flag", 32'(alarm), 32'd0);
    tick(1);
    check_output("alarm_flag", 32'(alarm), 32'd1);
    check_output("alarm_motor", 32'(motor_en), 32'd0);
    check_output("alarm_pattern", 32'(pattern), 32'd0);
    tick(1);
    apply_stimulus(1, 0, 0, 0, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("alarm_ignores_start", 32'(alarm), 32'd1);
    tick(2);
    apply_stimulus(0, 1, 0, 0, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("alarm_cleared", 32'(alarm), 32'd0);
    check_output("alarm_stop_busy", 32'(busy), 32'd0);

    // asynchronous reset in the middle of SETTLE
    tick(2);
    apply_stimulus(1, 0, 0, 0, 0);
    tick(1);
    apply_stimulus(0, 0, 0, 0, 0);
    tick(3);
    #2 reset = 1'b1;
    #1;
    check_output("areset_motor", 32'(motor_en), 32'd0);
    check_output("areset_busy", 32'(busy), 32'd0);
    check_output("areset_detclr", 32'(det_clear), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check_output("areset_no_detclr", 32'(det_clear), 32'd0);
    check_output("areset_idle", 32'(busy), 32'd0);
    tick(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
